// File: rtl/ccl_pkg.sv
// Shared types and constants for the channel-control request scheduler.
package ccl_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } ccl_state_e;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_ERR   = 3;
  localparam int GNT_CCWF  = 2;
  localparam int GNT_ACT   = 1;
  localparam int GNT_STORE = 0;

  // Fixed word counts for the non-store sources
  localparam logic [2:0] NWD_ERR  = 3'd1;
  localparam logic [2:0] NWD_CCWF = 3'd1;
  localparam logic [2:0] NWD_ACT  = 3'd2;

  // Cycles without memory activity before the transaction is abandoned
  localparam logic [7:0] CCL_TIMEOUT = 8'd255;

  // Index of the final word for the granted source (word count minus one)
  function automatic logic [1:0] ccl_last_idx(input logic [3:0] gnt,
                                              input logic [1:0] store_nwd);
    logic [2:0] nwd;
    logic [2:0] last;
    nwd = {1'b0, store_nwd} + 3'd1;
    if (gnt[GNT_ERR])       nwd = NWD_ERR;
    else if (gnt[GNT_CCWF]) nwd = NWD_CCWF;
    else if (gnt[GNT_ACT])  nwd = NWD_ACT;
    last = nwd - 3'd1;
    return last[1:0];
  endfunction

endpackage

// File: rtl/ccl_prio_enc.sv
// Fixed-priority encoder: highest-index request wins, output is one-hot or zero.
module ccl_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // Scan from the top bit down; first set bit claims the grant
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (gnt == '0)) gnt[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ccl_req_sched.sv
// Channel-control memory request scheduler: arbitrates four requesters onto
// one memory port, counts transferred words and aborts on memory timeout.
module ccl_req_sched
  import ccl_pkg::*;
(
  input  logic       clk_ccl_h,
  input  logic       mr_reset_h,
  input  logic       ccl_err_req_h,
  input  logic       ccl_ccwf_req_h,
  input  logic       ccl_act_flag_req_h,
  input  logic       ccl_store_req_h,
  input  logic [1:0] ccl_store_nwd_h,
  input  logic       mem_ack_h,
  input  logic       mem_wd_h,
  output logic       ccl_chan_req_h,
  output logic [3:0] ccl_grant_h,
  output logic [1:0] ccl_wd_sel_h,
  output logic       ccl_xfer_done_h,
  output logic       ccl_nxm_err_h,
  output logic       ccl_busy_h
);

  ccl_state_e state;
  logic [3:0] req_vec;
  logic [3:0] win;
  logic [3:0] grant;
  logic [1:0] wd_sel;
  logic [1:0] last_idx;
  logic [7:0] tmo;
  logic       nxm;
  logic       active;
  logic       abort;

  // Pack requests into grant-bit order for the encoder
  always_comb begin
    req_vec            = '0;
    req_vec[GNT_ERR]   = ccl_err_req_h;
    req_vec[GNT_CCWF]  = ccl_ccwf_req_h;
    req_vec[GNT_ACT]   = ccl_act_flag_req_h;
    req_vec[GNT_STORE] = ccl_store_req_h;
  end

  ccl_prio_enc #(.N(4)) u_prio_enc (
    .req (req_vec),
    .gnt (win)
  );

  // Timeout fires on the edge where the counter would step onto the limit
  assign active = (state == ST_REQ) || (state == ST_DATA);
  assign abort  = active && !mem_ack_h && !mem_wd_h && (tmo == CCL_TIMEOUT - 8'd1);

  // Idle-cycle counter: cleared on REQ entry and any memory activity
  always_ff @(posedge clk_ccl_h or posedge mr_reset_h) begin
    if (mr_reset_h)                               tmo <= '0;
    else if ((state == ST_IDLE) && (|req_vec))    tmo <= '0;
    else if (active && (mem_ack_h || mem_wd_h))   tmo <= '0;
    else if (active)                              tmo <= tmo + 8'd1;
  end

  // Arbitration, word tracking and transaction sequencing
  always_ff @(posedge clk_ccl_h or posedge mr_reset_h) begin
    if (mr_reset_h) begin
      state    <= ST_IDLE;
      grant    <= '0;
      wd_sel   <= '0;
      last_idx <= '0;
      nxm      <= 1'b0;
    end else begin
      nxm <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        grant  <= '0;
        wd_sel <= '0;
        nxm    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (|req_vec) begin
            state    <= ST_REQ;
            grant    <= win;
            last_idx <= ccl_last_idx(win, ccl_store_nwd_h);
            wd_sel   <= '0;
          end
          // A word strobe only counts here once the request is accepted
          ST_REQ: if (mem_ack_h) begin
            if (mem_wd_h && (wd_sel == last_idx)) state <= ST_DONE;
            else begin
              state <= ST_DATA;
              if (mem_wd_h) wd_sel <= wd_sel + 2'd1;
            end
          end
          ST_DATA: if (mem_wd_h) begin
            if (wd_sel == last_idx) state <= ST_DONE;
            else                    wd_sel <= wd_sel + 2'd1;
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            grant  <= '0;
            wd_sel <= '0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ccl_chan_req_h  = (state == ST_REQ);
  assign ccl_grant_h     = grant;
  assign ccl_wd_sel_h    = wd_sel;
  assign ccl_xfer_done_h = (state == ST_DONE);
  assign ccl_nxm_err_h   = nxm;
  assign ccl_busy_h      = (state != ST_IDLE);

endmodule

// File: tb/tb_ccl_req_sched.sv
// Directed bench for ccl_req_sched: arbitration order, word sequencing,
// timeout abort, mid-transaction requests and asynchronous reset.
module tb_ccl_req_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_req, ccwf_req, act_req, store_req;
  logic [1:0] store_nwd;
  logic       ack, wd;
  logic       chan_req;
  logic [3:0] grant;
  logic [1:0] wd_sel;
  logic       done, nxm, busy;

  int checks = 0;
  int errors = 0;

  ccl_req_sched dut (
    .clk_ccl_h          (clk),
    .mr_reset_h         (rst),
    .ccl_err_req_h      (err_req),
    .ccl_ccwf_req_h     (ccwf_req),
    .ccl_act_flag_req_h (act_req),
    .ccl_store_req_h    (store_req),
    .ccl_store_nwd_h    (store_nwd),
    .mem_ack_h          (ack),
    .mem_wd_h           (wd),
    .ccl_chan_req_h     (chan_req),
    .ccl_grant_h        (grant),
    .ccl_wd_sel_h       (wd_sel),
    .ccl_xfer_done_h    (done),
    .ccl_nxm_err_h      (nxm),
    .ccl_busy_h         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole output bundle as {chan_req, done, nxm, busy, grant}
  function automatic logic [7:0] outs();
    return {chan_req, done, nxm, busy, grant};
  endfunction

  int done_seen;
  int nxm_seen;

  initial begin
    rst = 1'b1;
    err_req = 0; ccwf_req = 0; act_req = 0; store_req = 0;
    store_nwd = 2'd0; ack = 0; wd = 0;

    // Reset state
    tick(); tick();
    chk("reset_outs", outs(), 8'h00);
    chk("reset_wdsel", {6'd0, wd_sel}, 8'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_release", outs(), 8'h00);

    // ccwf beats store; one-word ccwf, then store after one IDLE cycle
    ccwf_req = 1; store_req = 1;
    tick();
    chk("A_c1_grant", {4'd0, grant}, 8'b0100);
    chk("A_c1_chanreq", {7'd0, chan_req}, 8'd1);
    ccwf_req = 0;
    tick();
    chk("A_c2_req_held", outs(), {4'b1001, 4'b0100});
    ack = 1; wd = 1;
    tick();
    chk("A_c3_done", outs(), {4'b0101, 4'b0100});
    ack = 0; wd = 0;
    tick();
    chk("A_c4_idle", outs(), 8'h00);
    tick();
    chk("A_c5_store_grant", outs(), {4'b1001, 4'b0001});
    ack = 1; wd = 1;
    tick();
    chk("A_store_done", outs(), {4'b0101, 4'b0001});
    ack = 0; wd = 0; store_req = 0;
    tick();
    chk("A_back_idle", outs(), 8'h00);

    // Four-word store; request dropped after ack, nwd changed after grant
    store_req = 1; store_nwd = 2'd3;
    tick();
    chk("B_grant", outs(), {4'b1001, 4'b0001});
    ack = 1;
    tick();
    chk("B_data_entry", outs(), {4'b0001, 4'b0001});
    ack = 0; store_req = 0; store_nwd = 2'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("B_wdsel%0d", i), {6'd0, wd_sel}, 8'(i));
      chk($sformatf("B_hold%0d", i), outs(), {4'b0001, 4'b0001});
      wd = 1;
      tick();
      wd = 0;
      if (i < 3) tick();
    end
    chk("B_done", outs(), {4'b0101, 4'b0001});
    tick();
    chk("B_idle", outs(), 8'h00);
    chk("B_idle_wdsel", {6'd0, wd_sel}, 8'd0);

    // act_flag with no memory response: abort after 255 silent cycles
    act_req = 1;
    tick();
    chk("C_grant", outs(), {4'b1001, 4'b0010});
    done_seen = 0; nxm_seen = 0;
    for (int k = 1; k < 255; k++) begin
      if (done) done_seen++;
      if (nxm) nxm_seen++;
      tick();
    end
    chk("C_no_early_pulse", 8'(done_seen + nxm_seen), 8'd0);
    chk("C_last_req_cycle", outs(), {4'b1001, 4'b0010});
    tick();
    chk("C_nxm_pulse", outs(), {4'b0010, 4'b0000});
    act_req = 0;
    tick();
    chk("C_nxm_one_cycle", outs(), 8'h00);

    // err raised during store DATA waits for the store to finish
    store_req = 1; store_nwd = 2'd1;
    tick();
    ack = 1; wd = 1;
    tick();
    chk("D_data_wd1", {6'd0, wd_sel}, 8'd1);
    ack = 0; wd = 0; err_req = 1; store_req = 0;
    tick();
    chk("D_store_kept", outs(), {4'b0001, 4'b0001});
    wd = 1;
    tick();
    chk("D_store_done", outs(), {4'b0101, 4'b0001});
    tick();
    chk("D_idle_gap", outs(), 8'h00);
    tick();
    chk("D_err_grant", outs(), {4'b1001, 4'b1000});
    chk("D_idle_wd_ignored", {6'd0, wd_sel}, 8'd0);
    tick();
    chk("D_wd_without_ack", {chan_req, 5'd0, wd_sel}, 8'h80);
    ack = 1;
    tick();
    chk("D_err_done", outs(), {4'b0101, 4'b1000});
    ack = 0; wd = 0; err_req = 0;
    tick();

    // Asynchronous reset between edges during DATA
    store_req = 1; store_nwd = 2'd2;
    tick();
    ack = 1;
    tick();
    ack = 0; wd = 1;
    tick();
    wd = 0;
    chk("E_mid_data", {6'd0, wd_sel}, 8'd1);
    #3 rst = 1'b1;
    #1;
    chk("E_async_outs", outs(), 8'h00);
    chk("E_async_wdsel", {6'd0, wd_sel}, 8'd0);
    store_req = 1; store_nwd = 2'd0;
    tick();
    chk("E_held_in_reset", outs(), 8'h00);
    rst = 1'b0;
    tick();
    chk("E_first_edge_grant", outs(), {4'b1001, 4'b0001});
    store_req = 0; ack = 1; wd = 1;
    tick();
    chk("E_done", outs(), {4'b0101, 4'b0001});
    ack = 0; wd = 0;
    done_seen = 0; nxm_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) done_seen++;
      if (nxm) nxm_seen++;
    end
    chk("E_quiet_after", 8'(done_seen + nxm_seen), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
